// File: rtl/cluster_frame_packer_pkg.sv
// rtl/cluster_frame_packer_pkg.sv - shared widths, FSM state type and word formatters for the cluster packer
package cluster_frame_packer_pkg;

  localparam int CLU_ADR_W  = 11;
  localparam int CLU_CNT_W  = 3;
  localparam int N_CLUSTERS = 8;
  localparam int BXN_W      = 12;
  localparam int NVALID_W   = 4;
  localparam int WORD_W     = 16;

  // Canonical empty-slot marker; any address at or above ADR_VALID_LIMIT is also treated as empty.
  localparam logic [CLU_ADR_W-1:0] ADR_INVALID     = 11'h7FF;
  localparam logic [CLU_ADR_W-1:0] ADR_VALID_LIMIT = 11'd1536;
  localparam logic                 HDR_MARK        = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_CLU
  } pack_state_t;

  // Header: marker bit, number of cluster words that follow, low 11 bits of the BX tag.
  function automatic logic [WORD_W-1:0] hdr_word(input logic [NVALID_W-1:0] nvalid,
                                                 input logic [BXN_W-1:0]    bxn);
    return {HDR_MARK, nvalid, bxn[CLU_ADR_W-1:0]};
  endfunction

  // Cluster word: two zero marker bits, cluster size, cluster address.
  function automatic logic [WORD_W-1:0] clu_word(input logic [CLU_CNT_W-1:0] cnt,
                                                 input logic [CLU_ADR_W-1:0] adr);
    return {2'b00, cnt, adr};
  endfunction

  // A slot carries a cluster only when its address is inside the strip range.
  function automatic logic slot_is_valid(input logic [CLU_ADR_W-1:0] adr);
    return (adr != ADR_INVALID) && (adr < ADR_VALID_LIMIT);
  endfunction

endpackage

// File: rtl/cluster_word_fifo.sv
// rtl/cluster_word_fifo.sv - first-word-fall-through word FIFO feeding the link serializer
module cluster_word_fifo
  import cluster_frame_packer_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                      clock4x,
  input  logic                      global_reset,
  input  logic                      wr_en,
  input  logic [WORD_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [WORD_W-1:0]         rd_data,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    free_words
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_rd;
  logic              do_wr;

  // A read frees a slot in the same cycle, so a write while full is allowed when a read accompanies it.
  always_comb begin
    do_rd = rd_en && (count != '0);
    do_wr = wr_en && ((count != DEPTH_W) || do_rd);
  end

  // Storage array; no reset needed because pointers define what is visible.
  always_ff @(posedge clock4x) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end

  assign rd_data    = mem[rd_ptr];
  assign empty      = (count == '0);
  assign free_words = DEPTH_W - count;

endmodule

// File: rtl/cluster_frame_packer.sv
// rtl/cluster_frame_packer.sv - tags BX clusters, drops empty slots, packs variable-length packets into a FIFO
module cluster_frame_packer
  import cluster_frame_packer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 64,
  parameter int BX_MAX         = 3563,
  parameter int SUPPRESS_EMPTY = 1
) (
  input  logic                            clock4x,
  input  logic                            global_reset,
  input  logic                            clusters_vld,
  input  logic [N_CLUSTERS*CLU_ADR_W-1:0] adr_in,
  input  logic [N_CLUSTERS*CLU_CNT_W-1:0] cnt_in,
  input  logic                            bc0,
  output logic [WORD_W-1:0]               dout,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            busy,
  output logic [15:0]                     drop_cnt
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  // Incoming slot decode
  logic [N_CLUSTERS-1:0]           in_mask;
  logic [NVALID_W-1:0]             in_nvalid;

  // BX numbering
  logic [BXN_W-1:0]                bxn;
  logic                            bx_seen;
  logic [BXN_W-1:0]                next_tag;

  // Single-entry pending buffer between capture and the packer FSM
  logic                            pend_full;
  logic [N_CLUSTERS*CLU_ADR_W-1:0] pend_adr;
  logic [N_CLUSTERS*CLU_CNT_W-1:0] pend_cnt;
  logic [N_CLUSTERS-1:0]           pend_mask;
  logic [NVALID_W-1:0]             pend_nvalid;
  logic [BXN_W-1:0]                pend_bxn;

  // Working copy owned by the FSM while a packet is being written
  pack_state_t                     state;
  logic [N_CLUSTERS*CLU_ADR_W-1:0] work_adr;
  logic [N_CLUSTERS*CLU_CNT_W-1:0] work_cnt;
  logic [N_CLUSTERS-1:0]           work_mask;
  logic [NVALID_W-1:0]             work_nvalid;
  logic [BXN_W-1:0]                work_bxn;

  // Next-slot selection
  logic [2:0]                      sel_idx;
  logic [N_CLUSTERS-1:0]           sel_onehot;
  logic [N_CLUSTERS-1:0]           rest_mask;
  logic [CLU_ADR_W-1:0]            sel_adr;
  logic [CLU_CNT_W-1:0]            sel_cnt;

  // Admission and drop decisions
  logic                            pend_take;
  logic                            pend_empty_skip;
  logic [FW-1:0]                   need_words;
  logic [FW-1:0]                   avail_words;
  logic                            adm_drop;
  logic                            cap_drop;

  // FIFO interface
  logic                            fifo_wr_en;
  logic [WORD_W-1:0]               fifo_wr_data;
  logic [WORD_W-1:0]               fifo_rd_data;
  logic                            fifo_empty;
  logic [FW-1:0]                   free_words;

  // Classify each incoming slot and count how many carry a cluster.
  always_comb begin
    in_mask   = '0;
    in_nvalid = '0;
    for (int k = 0; k < N_CLUSTERS; k++) begin
      in_mask[k] = slot_is_valid(adr_in[k*CLU_ADR_W +: CLU_ADR_W]);
      in_nvalid  = in_nvalid + {{(NVALID_W-1){1'b0}}, in_mask[k]};
    end
  end

  // Tag for the BX being strobed now: resync, first-after-reset, or increment with wrap.
  always_comb begin
    next_tag = '0;
    if (bc0 || !bx_seen) begin
      next_tag = '0;
    end else if (bxn == BXN_W'(BX_MAX)) begin
      next_tag = '0;
    end else begin
      next_tag = bxn + 1'b1;
    end
  end

  // BX counter advances on every strobe, including BXs that end up dropped.
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      bxn     <= '0;
      bx_seen <= 1'b0;
    end else if (clusters_vld) begin
      bxn     <= next_tag;
      bx_seen <= 1'b1;
    end
  end

  // The FSM empties the pending buffer whenever it is idle; the FIFO must hold the whole packet
  // including any word still sitting in the registered write stage.
  always_comb begin
    pend_take       = (state == ST_IDLE) && pend_full;
    pend_empty_skip = (pend_nvalid == '0) && (SUPPRESS_EMPTY != 0);
    need_words      = FW'(pend_nvalid) + 1'b1;
    avail_words     = free_words - FW'(fifo_wr_en);
    adm_drop        = pend_take && !pend_empty_skip && (avail_words < need_words);
    cap_drop        = clusters_vld && pend_full && !pend_take;
  end

  // Capture a strobed BX into the pending buffer unless the previous one is still waiting.
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      pend_full   <= 1'b0;
      pend_adr    <= '0;
      pend_cnt    <= '0;
      pend_mask   <= '0;
      pend_nvalid <= '0;
      pend_bxn    <= '0;
    end else if (clusters_vld && !cap_drop) begin
      pend_full   <= 1'b1;
      pend_adr    <= adr_in;
      pend_cnt    <= cnt_in;
      pend_mask   <= in_mask;
      pend_nvalid <= in_nvalid;
      pend_bxn    <= next_tag;
    end else if (pend_take) begin
      pend_full   <= 1'b0;
    end
  end

  // Saturating count of BXs lost either at capture or at FIFO admission.
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      drop_cnt <= '0;
    end else if ((cap_drop || adm_drop) && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Lowest remaining valid slot goes out next, so cluster words leave in ascending slot order.
  always_comb begin
    sel_idx = '0;
    for (int k = N_CLUSTERS-1; k >= 0; k--) begin
      if (work_mask[k]) begin
        sel_idx = 3'(k);
      end
    end
    sel_onehot = N_CLUSTERS'(1) << sel_idx;
    rest_mask  = work_mask & ~sel_onehot;
    sel_adr    = work_adr[int'(sel_idx)*CLU_ADR_W +: CLU_ADR_W];
    sel_cnt    = work_cnt[int'(sel_idx)*CLU_CNT_W +: CLU_CNT_W];
  end

  // Packer FSM with registered FIFO write port: IDLE loads and admits, HDR writes the header,
  // CLU writes one cluster word per cycle.
  always_ff @(posedge clock4x or posedge global_reset) begin
    if (global_reset) begin
      state        <= ST_IDLE;
      work_adr     <= '0;
      work_cnt     <= '0;
      work_mask    <= '0;
      work_nvalid  <= '0;
      work_bxn     <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pend_take) begin
            work_adr    <= pend_adr;
            work_cnt    <= pend_cnt;
            work_mask   <= pend_mask;
            work_nvalid <= pend_nvalid;
            work_bxn    <= pend_bxn;
            if (!pend_empty_skip && !adm_drop) begin
              state <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          fifo_wr_en   <= 1'b1;
          fifo_wr_data <= hdr_word(work_nvalid, work_bxn);
          state        <= (work_nvalid == '0) ? ST_IDLE : ST_CLU;
        end
        ST_CLU: begin
          fifo_wr_en   <= 1'b1;
          fifo_wr_data <= clu_word(sel_cnt, sel_adr);
          work_mask    <= rest_mask;
          if (rest_mask == '0) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  cluster_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock4x      (clock4x),
    .global_reset (global_reset),
    .wr_en        (fifo_wr_en),
    .wr_data      (fifo_wr_data),
    .rd_en        (dout_ready),
    .rd_data      (fifo_rd_data),
    .empty        (fifo_empty),
    .free_words   (free_words)
  );

  // Stale storage contents never reach the link: dout reads zero whenever nothing is queued.
  assign dout       = fifo_empty ? '0 : fifo_rd_data;
  assign dout_valid = !fifo_empty;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_cluster_frame_packer.sv
// tb/tb_cluster_frame_packer.sv - directed self-checking bench for cluster_frame_packer
module tb_cluster_frame_packer;

  logic        clock4x = 1'b0;
  logic        global_reset;
  logic        clusters_vld;
  logic [87:0] adr_in;
  logic [23:0] cnt_in;
  logic        bc0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  logic [87:0] full_adr;
  logic [23:0] full_cnt;
  logic [87:0] empty_adr;
  logic [87:0] two_adr;
  logic [23:0] two_cnt;

  cluster_frame_packer #(
    .FIFO_DEPTH     (64),
    .BX_MAX         (3563),
    .SUPPRESS_EMPTY (1)
  ) dut (
    .clock4x      (clock4x),
    .global_reset (global_reset),
    .clusters_vld (clusters_vld),
    .adr_in       (adr_in),
    .cnt_in       (cnt_in),
    .bc0          (bc0),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  always #5 clock4x = ~clock4x;

  // Record every word the consumer accepts.
  always @(negedge clock4x) begin
    if (!global_reset && dout_valid && dout_ready) begin
      got_q.push_back(dout);
    end
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock4x);
    #1;
  endtask

  // One strobe; the edge after the drive samples it, then wait out the rest of the gap.
  task automatic bx(input logic [87:0] a, input logic [23:0] c, input logic b, input int gap);
    adr_in       = a;
    cnt_in       = c;
    bc0          = b;
    clusters_vld = 1'b1;
    tick(1);
    clusters_vld = 1'b0;
    bc0          = 1'b0;
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic push_full(input int tag);
    exp_q.push_back(16'hC000 | 16'(tag & 'h7FF));
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(16'((k << 11) | (k * 'h40 + k + 1)));
    end
  endtask

  task automatic push_two();
    exp_q.push_back(16'h9000);
    exp_q.push_back(16'h1010);
    exp_q.push_back(16'h3DFF);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check($sformatf("%s_len", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    global_reset = 1'b1;
    tick(1);
    global_reset = 1'b0;
    tick(1);
    got_q.delete();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      full_adr[k*11 +: 11] = 11'(k * 'h40 + k + 1);
      full_cnt[k*3 +: 3]   = 3'(k);
    end
    empty_adr        = {8{11'h7FF}};
    two_adr          = {8{11'h7FF}};
    two_adr[0 +: 11] = 11'h600;
    two_adr[22 +: 11] = 11'h010;
    two_adr[55 +: 11] = 11'h5FF;
    two_cnt          = '0;
    two_cnt[0 +: 3]  = 3'd5;
    two_cnt[6 +: 3]  = 3'd2;
    two_cnt[15 +: 3] = 3'd7;

    global_reset = 1'b1;
    clusters_vld = 1'b0;
    adr_in       = '0;
    cnt_in       = '0;
    bc0          = 1'b0;
    dout_ready   = 1'b1;
    tick(3);
    check("rst_dout", dout, 16'h0);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop_cnt", drop_cnt, 16'h0);
    global_reset = 1'b0;
    tick(2);

    // Empty BXs are suppressed completely.
    for (int i = 0; i < 3; i++) bx(empty_adr, 24'h0, 1'b0, 8);
    tick(10);
    check("empty_words", got_q.size(), 0);
    check("empty_drop_cnt", drop_cnt, 16'h0);
    check("empty_busy", busy, 1'b0);

    // Two valid slots with resync; header appears three edges after the sampling edge.
    adr_in       = two_adr;
    cnt_in       = two_cnt;
    bc0          = 1'b1;
    clusters_vld = 1'b1;
    tick(1);
    clusters_vld = 1'b0;
    bc0          = 1'b0;
    tick(2);
    check("lat_n2_valid", dout_valid, 1'b0);
    tick(1);
    check("lat_n3_valid", dout_valid, 1'b1);
    check("lat_n3_dout", dout, 16'h9000);
    tick(10);
    push_two();
    compare_stream("two_slot");

    // Full BXs back to back, tags 1..4 following the resync.
    for (int t = 1; t <= 4; t++) begin
      push_full(t);
      bx(full_adr, full_cnt, 1'b0, 8);
    end
    tick(30);
    compare_stream("full_bx");
    check("full_drop_cnt", drop_cnt, 16'h0);

    // Consumer stalled: seven packets fit in 64 words, the rest are rejected at admission.
    dout_ready = 1'b0;
    for (int t = 5; t <= 14; t++) begin
      if (t <= 11) push_full(t);
      bx(full_adr, full_cnt, 1'b0, 12);
    end
    tick(10);
    check("stall_accepted", got_q.size(), 0);
    check("stall_dout_valid", dout_valid, 1'b1);
    check("stall_dout_hold", dout, 16'hC005);
    check("stall_drop_cnt", drop_cnt, 16'd3);
    dout_ready = 1'b1;
    tick(80);
    compare_stream("stall_drain");
    check("drain_empty", dout_valid, 1'b0);

    // Pending overlap: third strobe arrives while the second still waits.
    pulse_reset();
    push_full(0);
    push_full(1);
    bx(full_adr, full_cnt, 1'b0, 4);
    bx(full_adr, full_cnt, 1'b0, 4);
    check("overlap_busy", busy, 1'b1);
    bx(full_adr, full_cnt, 1'b0, 4);
    tick(30);
    compare_stream("overlap");
    check("overlap_drop_cnt", drop_cnt, 16'd1);

    // Asynchronous reset in the middle of a packet.
    bx(full_adr, full_cnt, 1'b0, 5);
    check("mid_busy", busy, 1'b1);
    check("mid_dout_valid", dout_valid, 1'b1);
    #2;
    global_reset = 1'b1;
    #1;
    check("async_dout_valid", dout_valid, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_drop_cnt", drop_cnt, 16'h0);
    check("async_dout", dout, 16'h0);
    tick(1);
    global_reset = 1'b0;
    tick(2);
    got_q.delete();
    bx(two_adr, two_cnt, 1'b0, 15);
    push_two();
    compare_stream("post_reset");

    // BX number wrap: tags 0..3562 on empty BXs, then 3563 and 0 on full ones.
    pulse_reset();
    for (int t = 0; t <= 3562; t++) bx(empty_adr, 24'h0, 1'b0, 8);
    push_full(3563);
    bx(full_adr, full_cnt, 1'b0, 12);
    push_full(0);
    bx(full_adr, full_cnt, 1'b0, 12);
    tick(20);
    compare_stream("wrap");
    check("wrap_drop_cnt", drop_cnt, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
